// File: rtl/rotary_multi.sv
// Multi-channel rotary-encoder decoder: per channel it synchronises, debounces and decodes a
// T-phase active-low encoder into steps driving a bounded, optionally accelerated counter.
module rotary_multi #(
  parameter int unsigned CH       = 2,
  parameter int unsigned N        = 12,
  parameter int unsigned INIT     = 0,
  parameter int unsigned SAT      = 1,
  parameter int unsigned T        = 3,
  parameter int unsigned DEB      = 40000,
  parameter int unsigned HOLD     = 200000,
  parameter int unsigned ACC      = 0,
  parameter int unsigned ACC_WIN  = 2000000,
  parameter int unsigned ACC_STEP = 4,
  localparam int unsigned W       = (N < 2) ? 1 : $clog2(N)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [CH*T-1:0]   rot_ni,
  input  logic [CH-1:0]     load_i,
  input  logic [W-1:0]      load_val_i,
  output logic [CH*W-1:0]   counter_o,
  output logic [CH-1:0]     inc_o,
  output logic [CH-1:0]     dec_o
);

  localparam int unsigned W1 = W + 1;
  localparam int unsigned SW = (DEB < 1) ? 1 : $clog2(DEB + 1);
  localparam int unsigned HW = (HOLD < 1) ? 1 : $clog2(HOLD + 1);
  localparam int unsigned GW = (ACC_WIN < 1) ? 1 : $clog2(ACC_WIN + 1);

  localparam logic [SW-1:0] DebMax  = SW'(DEB);
  localparam logic [HW-1:0] HoldMax = HW'(HOLD);
  localparam logic [GW-1:0] GapMax  = GW'(ACC_WIN);
  localparam logic [W-1:0]  NMax    = W'(N - 1);
  localparam logic [W:0]    NMaxExt = W1'(N - 1);
  localparam logic [W:0]    NExt    = W1'(N);
  localparam logic [W:0]    StepAcc = W1'(ACC_STEP);
  localparam logic [W:0]    StepOne = W1'(1);
  localparam logic [W-1:0]  InitVal = W'(INIT);

  // A position code has exactly one phase low.
  function automatic logic is_pos(input logic [T-1:0] x);
    logic [T-1:0] n;
    n = ~x;
    return (n != '0) && ((n & (n - T'(1))) == '0);
  endfunction

  function automatic logic [T-1:0] fwd(input logic [T-1:0] x);
    return {x[0], x[T-1:1]};
  endfunction

  function automatic logic [T-1:0] bwd(input logic [T-1:0] x);
    return {x[T-2:0], x[T-1]};
  endfunction

  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic [T-1:0]  s1_q, s2_q, deb_q;
    logic [SW-1:0] scnt_q;
    logic [T-1:0]  anc_q, anc_d, cur_q, cur_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [GW-1:0] gcnt_q, gcnt_d;
    logic          ldir_q, ldir_d;
    logic [W-1:0]  out_q, out_d;
    logic          inc_q, inc_d, dec_q, dec_d;
    logic          deb_new, step_up, step_dn, accel;
    logic [W:0]    mag, out_ext, up_sum;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        s1_q   <= '1;
        s2_q   <= '1;
        deb_q  <= '1;
        scnt_q <= '0;
      end else begin
        s1_q <= rot_ni[c*T +: T];
        s2_q <= s1_q;
        if (s1_q != s2_q) begin
          scnt_q <= '0;
        end else if (scnt_q == DebMax) begin
          deb_q  <= s2_q;
          scnt_q <= '0;
        end else begin
          scnt_q <= scnt_q + SW'(1);
        end
      end
    end

    assign deb_new = is_pos(deb_q) && (deb_q != cur_q);

    always_comb begin
      anc_d   = anc_q;
      cur_d   = cur_q;
      hcnt_d  = hcnt_q;
      step_up = 1'b0;
      step_dn = 1'b0;
      if (anc_q == cur_q) begin
        if (deb_new) begin
          cur_d  = deb_q;
          hcnt_d = '0;
        end
      end else if (deb_new) begin
        cur_d  = deb_q;
        hcnt_d = '0;
        if (cur_q == fwd(anc_q) && deb_q == fwd(cur_q)) begin
          step_up = 1'b1;
          anc_d   = cur_q;
        end else if (cur_q == bwd(anc_q) && deb_q == bwd(cur_q)) begin
          step_dn = 1'b1;
          anc_d   = cur_q;
        end
      end else if (hcnt_q < HoldMax) begin
        hcnt_d = hcnt_q + HW'(1);
      end else begin
        // Slow commit: the tracked position becomes the anchor, stepping if it was adjacent.
        hcnt_d = '0;
        anc_d  = cur_q;
        if (cur_q == fwd(anc_q)) begin
          step_up = 1'b1;
        end else if (cur_q == bwd(anc_q)) begin
          step_dn = 1'b1;
        end
      end
    end

    assign accel   = (ACC != 0) && (gcnt_q < GapMax) && (step_up ? ldir_q : !ldir_q);
    assign mag     = accel ? StepAcc : StepOne;
    assign out_ext = {1'b0, out_q};
    assign up_sum  = out_ext + mag;

    always_comb begin
      out_d  = out_q;
      gcnt_d = (gcnt_q < GapMax) ? gcnt_q + GW'(1) : gcnt_q;
      ldir_d = ldir_q;
      inc_d  = 1'b0;
      dec_d  = 1'b0;
      if (load_i[c]) begin
        out_d  = (load_val_i > NMax) ? NMax : load_val_i;
        gcnt_d = GapMax;
      end else if (step_up) begin
        inc_d  = 1'b1;
        gcnt_d = '0;
        ldir_d = 1'b1;
        if (up_sum > NMaxExt) begin
          out_d = (SAT != 0) ? NMax : W'(up_sum - NExt);
        end else begin
          out_d = W'(up_sum);
        end
      end else if (step_dn) begin
        dec_d  = 1'b1;
        gcnt_d = '0;
        ldir_d = 1'b0;
        if (out_ext < mag) begin
          out_d = (SAT != 0) ? '0 : W'(out_ext + NExt - mag);
        end else begin
          out_d = W'(out_ext - mag);
        end
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        anc_q  <= '1;
        cur_q  <= '1;
        hcnt_q <= '0;
        gcnt_q <= GapMax;
        ldir_q <= 1'b0;
        out_q  <= InitVal;
        inc_q  <= 1'b0;
        dec_q  <= 1'b0;
      end else begin
        anc_q  <= anc_d;
        cur_q  <= cur_d;
        hcnt_q <= hcnt_d;
        gcnt_q <= gcnt_d;
        ldir_q <= ldir_d;
        out_q  <= out_d;
        inc_q  <= inc_d;
        dec_q  <= dec_d;
      end
    end

    assign counter_o[c*W +: W] = out_q;
    assign inc_o[c]            = inc_q;
    assign dec_o[c]            = dec_q;
  end

endmodule

// File: tb/tb_rotary_multi.sv
// Bench for rotary_multi: a saturating/accelerated and a wrapping/plain instance share random
// encoder, load and reset stimulus and are compared every cycle against a behavioural model.
module tb_rotary_multi;

  localparam int N        = 12;
  localparam int DEB      = 4;
  localparam int HOLD     = 20;
  localparam int ACC_WIN  = 50;
  localparam int ACC_STEP = 4;
  localparam int PSat  [2] = '{1, 0};
  localparam int PAcc  [2] = '{1, 0};
  localparam int PInit [2] = '{0, 11};

  logic       clk;
  logic       rst;
  logic [5:0] rot_n;
  logic [1:0] load;
  logic [3:0] load_val;
  logic [7:0] cnt_a, cnt_b;
  logic [1:0] inc_a, dec_a, inc_b, dec_b;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int inc_cnt [2];

  // Model state: [instance][channel]; codes as ints, anchor/cur as low-phase index (-1 = none).
  int s1_m [2][2], s2_m [2][2], deb_m [2][2], scnt_m [2][2];
  int anc_m [2][2], cur_m [2][2], hcnt_m [2][2], gcnt_m [2][2], ldir_m [2][2];
  int out_m [2][2], inc_m [2][2], dec_m [2][2];

  // Random stimulus state per channel.
  int st_p [2], st_hold [2], st_bias [2];
  int rst_hold = 0;

  rotary_multi #(
    .CH(2), .N(12), .INIT(0), .SAT(1), .T(3), .DEB(4), .HOLD(20),
    .ACC(1), .ACC_WIN(50), .ACC_STEP(4)
  ) u_sat (
    .clk_i(clk), .rst_i(rst), .rot_ni(rot_n), .load_i(load), .load_val_i(load_val),
    .counter_o(cnt_a), .inc_o(inc_a), .dec_o(dec_a)
  );

  rotary_multi #(
    .CH(2), .N(12), .INIT(11), .SAT(0), .T(3), .DEB(4), .HOLD(20),
    .ACC(0), .ACC_WIN(50), .ACC_STEP(4)
  ) u_wrap (
    .clk_i(clk), .rst_i(rst), .rot_ni(rot_n), .load_i(load), .load_val_i(load_val),
    .counter_o(cnt_b), .inc_o(inc_b), .dec_o(dec_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic int pos_of(input int code);
    int p = -1;
    int lows = 0;
    for (int i = 0; i < 3; i++) begin
      if (((code >> i) & 1) == 0) begin
        lows++;
        p = i;
      end
    end
    return (lows == 1) ? p : -1;
  endfunction

  // Forward rotation moves the low phase one place down; backward one place up.
  function automatic int fwd_i(input int p);
    return (p < 0) ? -9 : (p + 2) % 3;
  endfunction

  function automatic int bwd_i(input int p);
    return (p < 0) ? -9 : (p + 1) % 3;
  endfunction

  task automatic model_step();
    int rot, d, dir, m, v;
    for (int i = 0; i < 2; i++) begin
      for (int c = 0; c < 2; c++) begin
        rot = int'((rot_n >> (c * 3)) & 6'h7);
        if (rst) begin
          s1_m[i][c] = 7; s2_m[i][c] = 7; deb_m[i][c] = 7; scnt_m[i][c] = 0;
          anc_m[i][c] = -1; cur_m[i][c] = -1; hcnt_m[i][c] = 0;
          gcnt_m[i][c] = ACC_WIN; ldir_m[i][c] = -1;
          out_m[i][c] = PInit[i]; inc_m[i][c] = 0; dec_m[i][c] = 0;
        end else begin
          d   = pos_of(deb_m[i][c]);
          dir = 0;
          if (s1_m[i][c] != s2_m[i][c]) scnt_m[i][c] = 0;
          else if (scnt_m[i][c] == DEB) begin
            deb_m[i][c]  = s2_m[i][c];
            scnt_m[i][c] = 0;
          end else scnt_m[i][c]++;
          s2_m[i][c] = s1_m[i][c];
          s1_m[i][c] = rot;
          if (anc_m[i][c] == cur_m[i][c]) begin
            if (d >= 0 && d != cur_m[i][c]) begin
              cur_m[i][c]  = d;
              hcnt_m[i][c] = 0;
            end
          end else if (d >= 0 && d != cur_m[i][c]) begin
            if (cur_m[i][c] == fwd_i(anc_m[i][c]) && d == fwd_i(cur_m[i][c])) begin
              dir = 1; anc_m[i][c] = cur_m[i][c];
            end else if (cur_m[i][c] == bwd_i(anc_m[i][c]) && d == bwd_i(cur_m[i][c])) begin
              dir = -1; anc_m[i][c] = cur_m[i][c];
            end
            cur_m[i][c]  = d;
            hcnt_m[i][c] = 0;
          end else if (hcnt_m[i][c] < HOLD) begin
            hcnt_m[i][c]++;
          end else begin
            hcnt_m[i][c] = 0;
            if (cur_m[i][c] == fwd_i(anc_m[i][c])) dir = 1;
            else if (cur_m[i][c] == bwd_i(anc_m[i][c])) dir = -1;
            anc_m[i][c] = cur_m[i][c];
          end
          inc_m[i][c] = 0;
          dec_m[i][c] = 0;
          if (load[c]) begin
            out_m[i][c]  = (int'(load_val) > N - 1) ? N - 1 : int'(load_val);
            gcnt_m[i][c] = ACC_WIN;
          end else if (dir != 0) begin
            m = (PAcc[i] == 1 && gcnt_m[i][c] < ACC_WIN && dir == ldir_m[i][c]) ? ACC_STEP : 1;
            if (dir > 0) begin
              v = out_m[i][c] + m;
              if (v > N - 1) v = (PSat[i] == 1) ? N - 1 : v - N;
              inc_m[i][c] = 1;
            end else begin
              v = out_m[i][c] - m;
              if (v < 0) v = (PSat[i] == 1) ? 0 : v + N;
              dec_m[i][c] = 1;
            end
            out_m[i][c]  = v;
            gcnt_m[i][c] = 0;
            ldir_m[i][c] = dir;
          end else if (gcnt_m[i][c] < ACC_WIN) begin
            gcnt_m[i][c]++;
          end
        end
      end
    end
  endtask

  task automatic update_stim();
    int r, dur;
    logic [2:0] code;
    for (int c = 0; c < 2; c++) begin
      if (st_hold[c] > 0) st_hold[c]--;
      else begin
        r = $urandom_range(0, 99);
        if (r < 85) begin
          if ((r < 70) == (st_bias[c] == 1)) st_p[c] = (st_p[c] + 2) % 3;
          else st_p[c] = (st_p[c] + 1) % 3;
          code = 3'b111 & ~(3'b001 << st_p[c]);
        end else if (r < 92) code = 3'b111;
        else code = 3'($urandom_range(0, 7));
        if ($urandom_range(0, 9) == 0) st_bias[c] = 1 - st_bias[c];
        r = $urandom_range(0, 9);
        if (r == 0) dur = $urandom_range(1, 4);
        else if (r < 7) dur = $urandom_range(5, 16);
        else dur = $urandom_range(18, 40);
        st_hold[c] = dur - 1;
        rot_n[c*3 +: 3] = code;
      end
      load[c] = ($urandom_range(0, 49) == 0);
    end
    load_val = 4'($urandom_range(0, 15));
    if (rst_hold > 0) begin
      rst = 1'b1;
      rst_hold--;
    end else if ($urandom_range(0, 999) == 0) begin
      rst      = 1'b1;
      rst_hold = $urandom_range(0, 2);
    end else rst = 1'b0;
  endtask

  task automatic run(input int n, input bit rnd);
    logic [7:0] cv;
    logic [1:0] iv, dv;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      model_step();
      #1;
      cyc++;
      for (int i = 0; i < 2; i++) begin
        cv = (i == 0) ? cnt_a : cnt_b;
        iv = (i == 0) ? inc_a : inc_b;
        dv = (i == 0) ? dec_a : dec_b;
        for (int c = 0; c < 2; c++) begin
          check($sformatf("cnt%0d.%0d@%0d", i, c, cyc), 32'(cv[c*4 +: 4]), out_m[i][c]);
          check($sformatf("inc%0d.%0d@%0d", i, c, cyc), 32'(iv[c]), inc_m[i][c]);
          check($sformatf("dec%0d.%0d@%0d", i, c, cyc), 32'(dv[c]), dec_m[i][c]);
        end
      end
      inc_cnt[0] += int'(inc_a[0]);
      inc_cnt[1] += int'(inc_b[0]);
      if (rnd) update_stim();
    end
  endtask

  initial begin
    rst = 1'b1; rot_n = 6'h3f; load = 2'b00; load_val = 4'd0;
    run(2, 1'b0);
    rst = 1'b0;
    check("reset_cnt_sat", 32'(cnt_a), 32'h00);
    check("reset_cnt_wrap", 32'(cnt_b), 32'hbb);
    check("reset_inc", 32'({inc_a, inc_b}), 0);
    check("reset_dec", 32'({dec_a, dec_b}), 0);

    rot_n = 6'b111110;
    run(3, 1'b0);
    rot_n = 6'h3f;
    run(20, 1'b0);
    check("glitch_cnt_sat", 32'(cnt_a), 32'h00);
    check("glitch_cnt_wrap", 32'(cnt_b), 32'hbb);

    // Forward: 110 -> 011 -> 101; fast step then slow-commit step.
    inc_cnt[0] = 0;
    inc_cnt[1] = 0;
    rot_n[2:0] = 3'b110; run(30, 1'b0);
    rot_n[2:0] = 3'b011; run(10, 1'b0);
    rot_n[2:0] = 3'b101; run(40, 1'b0);
    check("fwd_sat_ch0", 32'(cnt_a[3:0]), 5);
    check("fwd_wrap_ch0", 32'(cnt_b[3:0]), 1);
    check("fwd_sat_ch1", 32'(cnt_a[7:4]), 0);
    check("fwd_wrap_ch1", 32'(cnt_b[7:4]), 11);
    check("fwd_inc_sat", inc_cnt[0], 2);
    check("fwd_inc_wrap", inc_cnt[1], 2);

    load = 2'b10; load_val = 4'd15;
    run(1, 1'b0);
    load = 2'b00;
    check("load_clamp_sat", 32'(cnt_a[7:4]), 11);
    check("load_clamp_wrap", 32'(cnt_b[7:4]), 11);

    st_p[0] = 1; st_p[1] = 0;
    st_hold[0] = 0; st_hold[1] = 0;
    st_bias[0] = 1; st_bias[1] = 0;
    run(12000, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
